// File: rtl/clock_set_controller.sv
// 24-hour BCD clock with a 1 Hz prescaler, debounced mode/inc buttons and a
// RUN -> SET_HOUR -> SET_MIN setting sequence driving blink-based blanking.
module clock_set_controller #(
   parameter int CLK_HZ          = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int BLINK_CYCLES    = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] sec_units,
   output logic [3:0] sec_tens,
   output logic [3:0] min_units,
   output logic [3:0] min_tens,
   output logic [3:0] hour_units,
   output logic [3:0] hour_tens,
   output logic [1:0] mode,
   output logic       tick_1hz,
   output logic       blank_hour,
   output logic       blank_min
);
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10
   } mode_e;

   // {carry, tens, units} for a 00..59 BCD pair
   function automatic logic [8:0] inc60(input logic [3:0] tens, input logic [3:0] units);
      logic [8:0] r;
      if (units != 4'd9)     r = {1'b0, tens, units + 4'd1};
      else if (tens != 4'd5) r = {1'b0, tens + 4'd1, 4'd0};
      else                   r = 9'h100;
      return r;
   endfunction

   function automatic logic [7:0] inc24(input logic [3:0] tens, input logic [3:0] units);
      logic [7:0] r;
      if (tens == 4'd2 && units == 4'd3) r = 8'h00;
      else if (units == 4'd9)            r = {tens + 4'd1, 4'd0};
      else                               r = {tens, units + 4'd1};
      return r;
   endfunction

   logic [1:0] btn_raw;
   logic [1:0] press;
   logic       mode_press;
   logic       inc_press;

   assign btn_raw = {btn_inc, btn_mode};

   // Press pulse fires one cycle after the accepted level rises
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_debounce
         logic [DW-1:0] cnt_q, cnt_d;
         logic          level_q, level_d;
         logic          level_dly_q, level_dly_d;
         logic          press_q, press_d;

         always_comb begin
            cnt_d       = '0;
            level_d     = level_q;
            level_dly_d = level_q;
            press_d     = level_q & ~level_dly_q;
            if (btn_raw[gi] != level_q) begin
               if (cnt_q == DEB_MAX) level_d = btn_raw[gi];
               else                  cnt_d   = cnt_q + DW'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q       <= '0;
               level_q     <= 1'b0;
               level_dly_q <= 1'b0;
               press_q     <= 1'b0;
            end else begin
               cnt_q       <= cnt_d;
               level_q     <= level_d;
               level_dly_q <= level_dly_d;
               press_q     <= press_d;
            end
         end

         assign press[gi] = press_q;
      end
   endgenerate

   assign mode_press = press[0];
   assign inc_press  = press[1];

   mode_e mode_q, mode_d;

   always_ff @(posedge clk) begin
      if (rst) mode_q <= RUN;
      else     mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      if (mode_press) begin
         case (mode_q)
            RUN:      mode_d = SET_HOUR;
            SET_HOUR: mode_d = SET_MIN;
            default:  mode_d = RUN;
         endcase
      end
   end

   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic          tick_q, tick_d;
   logic          blank_hour_q, blank_hour_d;
   logic          blank_min_q, blank_min_d;
   logic [3:0]    su_q, st_q, mu_q, mt_q, hu_q, ht_q;
   logic [3:0]    su_d, st_d, mu_d, mt_d, hu_d, ht_d;
   logic [8:0]    sec_inc, min_inc;
   logic [7:0]    hour_inc;

   always_comb begin
      blank_hour_d = (mode_d == SET_HOUR) && blink_phase_d;
      blank_min_d  = (mode_d == SET_MIN) && blink_phase_d;
   end

   always_comb begin
      sec_inc       = inc60(st_q, su_q);
      min_inc       = inc60(mt_q, mu_q);
      hour_inc      = inc24(ht_q, hu_q);
      {su_d, st_d}  = {su_q, st_q};
      {mu_d, mt_d}  = {mu_q, mt_q};
      {hu_d, ht_d}  = {hu_q, ht_q};
      presc_d       = '0;
      tick_d        = 1'b0;
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;

      // Leaving RUN suppresses a tick that would otherwise land in a SET mode
      if (mode_q == RUN && !mode_press) begin
         if (presc_q == PRESC_MAX) tick_d  = 1'b1;
         else                      presc_d = presc_q + PW'(1);
      end

      if (tick_q) begin
         {st_d, su_d} = sec_inc[7:0];
         if (sec_inc[8]) begin
            {mt_d, mu_d} = min_inc[7:0];
            if (min_inc[8]) {ht_d, hu_d} = hour_inc;
         end
      end

      if (mode_press) begin
         if (mode_q == SET_MIN) {st_d, su_d} = 8'h00;
      end else if (inc_press) begin
         if (mode_q == SET_HOUR)     {ht_d, hu_d} = hour_inc;
         else if (mode_q == SET_MIN) {mt_d, mu_d} = min_inc[7:0];
      end

      if (mode_d != mode_q) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q       <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         tick_q        <= 1'b0;
         blank_hour_q  <= 1'b0;
         blank_min_q   <= 1'b0;
         {su_q, st_q}  <= 8'h00;
         {mu_q, mt_q}  <= 8'h00;
         {hu_q, ht_q}  <= 8'h00;
      end else begin
         presc_q       <= presc_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         tick_q        <= tick_d;
         blank_hour_q  <= blank_hour_d;
         blank_min_q   <= blank_min_d;
         {su_q, st_q}  <= {su_d, st_d};
         {mu_q, mt_q}  <= {mu_d, mt_d};
         {hu_q, ht_q}  <= {hu_d, ht_d};
      end
   end

   assign sec_units  = su_q;
   assign sec_tens   = st_q;
   assign min_units  = mu_q;
   assign min_tens   = mt_q;
   assign hour_units = hu_q;
   assign hour_tens  = ht_q;
   assign mode       = mode_q;
   assign tick_1hz   = tick_q;
   assign blank_hour = blank_hour_q;
   assign blank_min  = blank_min_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// Randomized scoreboard bench for clock_set_controller: a seconds-count time
// model predicts each display change, a monitor checks tick and blink timing.
module tb_clock_set_controller;
   localparam int CLK_HZ = 10;
   localparam int DEB    = 4;
   localparam int BLK    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [3:0] sec_units, sec_tens, min_units, min_tens, hour_units, hour_tens;
   logic [1:0] mode;
   logic       tick_1hz, blank_hour, blank_min;

   always #5 clk = ~clk;

   clock_set_controller #(
      .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)
   ) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .sec_units(sec_units), .sec_tens(sec_tens),
      .min_units(min_units), .min_tens(min_tens),
      .hour_units(hour_units), .hour_tens(hour_tens),
      .mode(mode), .tick_1hz(tick_1hz),
      .blank_hour(blank_hour), .blank_min(blank_min)
   );

   typedef struct packed {
      logic [23:0] bcd;   // hh mm ss, tens digit first
      logic [1:0]  mode;
   } obs_t;

   obs_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   m_hh = 0, m_mm = 0, m_ss = 0, m_mode = 0;

   function automatic logic [7:0] bcd2(input int v);
      logic [7:0] r;
      r = {4'(v / 10), 4'(v % 10)};
      return r;
   endfunction

   function automatic obs_t make_obs(input int h, input int m, input int s, input int md);
      obs_t o;
      o.bcd  = {bcd2(h), bcd2(m), bcd2(s)};
      o.mode = 2'(md);
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.bcd  = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
      o.mode = mode;
      return o;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic push_exp();
      exp_q.push_back(make_obs(m_hh, m_mm, m_ss, m_mode));
   endtask

   task automatic model_tick();
      int t;
      t    = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
      m_hh = t / 3600;
      m_mm = (t / 60) % 60;
      m_ss = t % 60;
   endtask

   task automatic model_mode();
      if (m_mode == 0)      m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      else begin
         m_mode = 0;
         m_ss   = 0;
      end
   endtask

   task automatic model_inc(output bit changed);
      changed = 1'b1;
      if (m_mode == 1)      m_hh = (m_hh + 1) % 24;
      else if (m_mode == 2) m_mm = (m_mm + 1) % 60;
      else                  changed = 1'b0;
   endtask

   // Monitor: pops one expectation per visible change; checks tick/blink per cycle
   initial begin : monitor
      obs_t prev, cur, e;
      int   k;
      bit   started, phase;
      k       = 0;
      started = 1'b0;
      prev    = '0;
      forever begin
         @(posedge clk);
         #1;
         cur = dut_obs();
         if (rst) begin
            check("reset_state", 32'(cur), 32'(0));
            check("reset_tick", 32'(tick_1hz), 32'(0));
            check("reset_blank", 32'({blank_hour, blank_min}), 32'(0));
            prev    = cur;
            k       = 0;
            started = 1'b1;
         end else if (started) begin
            if (cur != prev) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_change actual=%0h required=none at %0t", cur, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("scoreboard", 32'(cur), 32'(e));
               end
               if (cur.mode != prev.mode) k = 0;
               else                       k++;
               prev = cur;
            end else begin
               k++;
            end
            phase = ((k / BLK) % 2) == 1;
            check("tick", 32'(tick_1hz), 32'(cur.mode == 2'd0 && k > 0 && (k % CLK_HZ) == 0));
            check("blank_hour", 32'(blank_hour), 32'(cur.mode == 2'd1 && phase));
            check("blank_min", 32'(blank_min), 32'(cur.mode == 2'd2 && phase));
         end
      end
   end

   task automatic press(input bit pm, input bit pi, input int len);
      bit ch;
      if (len >= DEB) begin
         if (pm) begin
            model_mode();
            push_exp();
         end else if (pi) begin
            model_inc(ch);
            if (ch) push_exp();
         end
      end
      btn_mode = pm;
      btn_inc  = pi;
      repeat (len) @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (DEB + 2) @(negedge clk);
   endtask

   // Returns on the negedge of the cycle in which the n-th tick is seen
   task automatic run_ticks(input int n, input int inc_hold);
      int seen, cyc;
      seen = 0;
      cyc  = 0;
      for (int i = 0; i < n; i++) begin
         model_tick();
         push_exp();
      end
      if (inc_hold > 0) btn_inc = 1'b1;
      while (seen < n && cyc < (n + 2) * CLK_HZ) begin
         @(negedge clk);
         cyc++;
         if (cyc == inc_hold) btn_inc = 1'b0;
         if (tick_1hz) seen++;
      end
      btn_inc = 1'b0;
      check("tick_count", 32'(seen), 32'(n));
   endtask

   task automatic do_reset();
      repeat (2) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_hh = 0; m_mm = 0; m_ss = 0; m_mode = 0;
   endtask

   initial begin : watchdog
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit   ch;
      int   old_h, r;
      obs_t o;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // carry chain with an ignored inc press in RUN
      run_ticks(60, 5);
      check("carry_60", 32'(m_mm * 60 + m_ss), 32'(60));

      // set sequence from 00:00:37
      do_reset();
      run_ticks(37, 0);
      press(1'b1, 1'b0, 4);
      for (int i = 0; i < 25; i++) press(1'b0, 1'b1, int'($urandom_range(4, 7)));
      press(1'b1, 1'b0, 5);
      for (int i = 0; i < 61; i++) press(1'b0, 1'b1, int'($urandom_range(4, 7)));
      press(1'b1, 1'b0, 4);
      o = make_obs(1, 1, 0, 0);
      check("set_sequence", 32'(dut_obs()), 32'(o));
      run_ticks(2, 6);

      // debounce in SET_HOUR
      press(1'b1, 1'b0, 4);
      press(1'b0, 1'b1, 3);
      old_h = m_hh;
      model_inc(ch);
      push_exp();
      btn_inc = 1'b1;
      repeat (5) @(negedge clk);
      check("inc_latency_early", 32'({hour_tens, hour_units}), 32'(bcd2(old_h)));
      @(negedge clk);
      check("inc_latency_due", 32'({hour_tens, hour_units}), 32'(bcd2(m_hh)));
      btn_inc = 1'b0;
      repeat (DEB + 2) @(negedge clk);
      press(1'b0, 1'b1, 100);

      // simultaneous presses, then tick coinciding with a mode press
      press(1'b1, 1'b1, 4);
      press(1'b1, 1'b0, 4);
      run_ticks(3, 0);
      model_tick();
      model_mode();
      push_exp();
      repeat (5) @(negedge clk);
      btn_mode = 1'b1;
      repeat (DEB) @(negedge clk);
      btn_mode = 1'b0;
      repeat (DEB + 2) @(negedge clk);

      // rollover from 23:59:58
      while (m_hh != 23) press(1'b0, 1'b1, DEB);
      press(1'b1, 1'b0, DEB);
      while (m_mm != 59) press(1'b0, 1'b1, DEB);
      press(1'b1, 1'b0, DEB);
      run_ticks(58, 0);
      run_ticks(2, 0);
      @(negedge clk);
      o = make_obs(0, 0, 0, 0);
      check("rollover", 32'(dut_obs()), 32'(o));

      // randomized operation mix
      for (int i = 0; i < 40; i++) begin
         if (m_mode == 0) begin
            run_ticks(int'($urandom_range(2, 3)), int'($urandom_range(0, 8)));
            press(1'b1, 1'b0, int'($urandom_range(4, 7)));
         end else begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      press(1'b0, 1'b1, int'($urandom_range(1, 8)));
            else if (r < 85) press(1'b1, 1'b0, int'($urandom_range(2, 7)));
            else             press(1'b1, 1'b1, int'($urandom_range(4, 7)));
         end
      end

      // reset mid-debounce while in SET_MIN
      do_reset();
      run_ticks(2, 0);
      press(1'b1, 1'b0, 4);
      press(1'b1, 1'b0, 4);
      repeat (10) @(negedge clk);
      btn_inc = 1'b1;
      repeat (2) @(negedge clk);
      check("queue_before_rst", 32'(exp_q.size()), 32'(0));
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      btn_inc = 1'b0;
      m_hh = 0; m_mm = 0; m_ss = 0; m_mode = 0;
      run_ticks(2, 0);

      repeat (3) @(negedge clk);
      check("queue_final", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
